variable_delay_mc: RTL and testbench
====================================

Name: variable_delay_mc

Overview:
- Multi-channel, run-time-adjustable delay line for SPI-style control/data lines (CS, SCLK, SDO, ...).
- Every channel is delayed by the same programmable number of clk cycles, from 0 (combinational pass-through) to DEPTH-1.
- The delay is set by two debounced push-buttons (up/down), with selectable wrap or saturate at the ends.
- Sits between the host SPI pins and the target device, to sweep timing skew on the bench.

Parameters:
- CH, 3: number of delayed channels.
- DEPTH, 16: number of delay settings; len ranges 0..DEPTH-1; must be >=2.
- DIV, 50000: clk cycles per debounce sample tick (sample_en); must be >=2.
- N, 8: consecutive equal samples required to accept a new button level; must be >=2.
- WRAP, 1: 1 = len wraps at both ends; 0 = len saturates at both ends.

Ports:
- clk  in  1  system clock; all state is clocked on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  CH  undelayed channel inputs, synchronous to clk.
- btn_up_raw  in  1  raw, bouncing, asynchronous "increase delay" button.
- btn_dn_raw  in  1  raw, bouncing, asynchronous "decrease delay" button.
- dout  out  CH  delayed channel outputs.
- len  out  LW  current delay setting; LW = max(1, clog2(DEPTH)).
- len_changed  out  1  one-cycle pulse when len takes a new value.

Behaviour:
- Reset, asynchronous and active-high. While rst=1:
  - len=0, len_changed=0.
  - All delay stages = 0.
  - Both synchronisers, histories and stable flags = 0.
  - Prescaler = 0.
  - dout = din (the len=0 bypass path).
- Delay line:
  - Stage s[0] <= din; s[i] <= s[i-1]. There are DEPTH-1 stages, each CH wide.
  - All stages shift on every clk edge, whatever the value of len.
  - len=0: dout = din combinationally, with no register in the path.
  - len=k (k>=1): dout = s[k-1], so the output equals din from exactly k cycles earlier.
  - A change in len takes effect on the cycle after the len register updates.
  - dout then immediately shows the tap for the new length. Glitches or repeated samples at the switch are permitted; no flush is performed.
- Debounce (one instance per button):
  - Raw input passes through a 2-flop synchroniser.
  - The prescaler counts 0..DIV-1 and asserts sample_en for one cycle when it reaches DIV-1, then returns to 0. The prescaler is shared by both buttons.
  - On sample_en, the synchronised bit shifts into an N-bit history.
  - When the history is all ones, stable becomes 1; when it is all zeros, stable becomes 0. Otherwise stable holds.
  - press pulse = stable rising edge, registered: high for exactly one cycle, in the cycle after stable goes 1.
  - A release produces no event.
- len update, on the clock edge where a press pulse is high:
  - up only, len<DEPTH-1: len+1.
  - up only, len=DEPTH-1: 0 if WRAP=1, else hold.
  - down only, len>0: len-1.
  - down only, len=0: DEPTH-1 if WRAP=1, else hold.
  - up and down in the same cycle: no change.
- len arithmetic is modulo DEPTH, not modulo 2^LW. For example, DEPTH=12 wraps 11->0.
- len_changed = 1 for exactly the one cycle after a len update in which the new value differs from the old one. A saturated hold produces no pulse.
- Holding a button produces exactly one step; there is no auto-repeat.
- Reset mid-operation: everything returns to its reset state immediately. A button that is still held after reset deasserts produces one press once N stable samples have been collected.

Decomposition:
- Package variable_delay_pkg holds:
  - function len_width(DEPTH), returning max(1, clog2(DEPTH));
  - localparam defaults DEF_DIV and DEF_N;
  - constants for the two step directions.
- One sub-module, btn_debounce, with parameter N and ports clk, rst, sample_en, raw, stable, press. It contains the synchroniser, the history register and the edge detector. It is instantiated twice.
- The prescaler, len counter and delay line live in the top level.

Test Plan (bench uses DIV=16, N=3, DEPTH=16, CH=3 unless stated):
- Reset, then din=3'b101 with no buttons: len=0 and dout==din within #1 of every din change (combinational); len_changed stays 0.
- Up button bounces for 4 cycles, then holds 1 for 3 sample ticks, then releases: len goes 0->1 with exactly one len_changed pulse; a 1-cycle din[0] pulse then appears on dout[0] exactly 1 cycle later and lasts 1 cycle.
- Step to len=5 and drive walking patterns on all CH: dout[i] equals din[i] from 5 cycles earlier for 50 cycles; the channels do not cross-talk.
- With len=15 and WRAP=1, press up -> len=0 (pulse); press down -> len=15 (pulse). With WRAP=0 at len=15, press up -> len holds at 15 and no pulse; at len=0, press down -> len holds at 0.
- Force both press pulses in the same cycle at len=7 -> len stays 7 and no pulse. Run a DEPTH=12, WRAP=1 variant: at len=11, press up -> len=0.
- Assert rst while len=9 and mid-debounce (history partially filled): len=0, dout==din, and no spurious press after release. Holding up across the rst deassert -> exactly one increment to 1.

Source files
------------

// File: rtl/variable_delay_pkg.sv
// Shared definitions for the multi-channel variable delay line.
package variable_delay_pkg;

  localparam int DEF_DIV = 50000;
  localparam int DEF_N   = 8;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_t;

  // Width of the len register; never narrower than one bit.
  function automatic int len_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser, sampled history and press-edge detector for one push-button.
module btn_debounce
  import variable_delay_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic raw,
  output logic stable,
  output logic press
);

  logic [1:0]   sync;
  logic [N-1:0] hist;
  logic         stable_q;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], raw};
  end

  // Shift the synchronised level into the history on each sample tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            hist <= '0;
    else if (sample_en) hist <= {hist[N-2:0], sync[1]};
  end

  // Accept a new level only once the whole history agrees on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          stable <= 1'b0;
    else if (&hist)   stable <= 1'b1;
    else if (~|hist)  stable <= 1'b0;
  end

  // Registered rising-edge detect: one-cycle press, releases are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= 1'b0;
      press    <= 1'b0;
    end else begin
      stable_q <= stable;
      press    <= stable & ~stable_q;
    end
  end

endmodule

// File: rtl/variable_delay_mc.sv
// Multi-channel delay line whose length is stepped by two debounced buttons.
module variable_delay_mc
  import variable_delay_pkg::*;
#(
  parameter int CH    = 3,
  parameter int DEPTH = 16,
  parameter int DIV   = DEF_DIV,
  parameter int N     = DEF_N,
  parameter int WRAP  = 1,
  localparam int LW   = len_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] din,
  input  logic          btn_up_raw,
  input  logic          btn_dn_raw,
  output logic [CH-1:0] dout,
  output logic [LW-1:0] len,
  output logic          len_changed
);

  localparam int PW = $clog2(DIV);

  logic [PW-1:0] presc;
  logic          sample_en;
  logic          up_stable, dn_stable, up_press, dn_press;
  logic          unused_stable;
  step_t         step;
  logic [LW-1:0] len_next;
  logic [CH-1:0] stages [DEPTH-1];

  assign sample_en     = (presc == PW'(DIV - 1));
  assign unused_stable = up_stable ^ dn_stable;

  // Shared prescaler producing one sample tick every DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            presc <= '0;
    else if (sample_en) presc <= '0;
    else                presc <= presc + 1'b1;
  end

  btn_debounce #(.N(N)) u_up (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .raw       (btn_up_raw),
    .stable    (up_stable),
    .press     (up_press)
  );

  btn_debounce #(.N(N)) u_dn (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .raw       (btn_dn_raw),
    .stable    (dn_stable),
    .press     (dn_press)
  );

  // Decode the press pulses into a direction; simultaneous presses cancel.
  always_comb begin
    step = STEP_HOLD;
    if (up_press && !dn_press)      step = STEP_UP;
    else if (dn_press && !up_press) step = STEP_DOWN;
  end

  // Next length, modulo DEPTH with wrap or saturation at the ends.
  always_comb begin
    len_next = len;
    case (step)
      STEP_UP: begin
        if (len == LW'(DEPTH - 1)) len_next = (WRAP != 0) ? '0 : len;
        else                       len_next = len + 1'b1;
      end
      STEP_DOWN: begin
        if (len == '0) len_next = (WRAP != 0) ? LW'(DEPTH - 1) : len;
        else           len_next = len - 1'b1;
      end
      default: len_next = len;
    endcase
  end

  // Length register plus a pulse whenever it actually moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len         <= '0;
      len_changed <= 1'b0;
    end else begin
      len         <= len_next;
      len_changed <= (len_next != len);
    end
  end

  // Free-running shift chain; every stage moves on every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH - 1; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH - 1; i++) stages[i] <= stages[i-1];
    end
  end

  // Output tap: len=0 is a pure wire, otherwise stage len-1.
  always_comb begin
    dout = din;
    for (int i = 1; i < DEPTH; i++) begin
      if (len == LW'(i)) dout = stages[i-1];
    end
  end

endmodule

// File: tb/tb_variable_delay_mc.sv
// Randomised bench for variable_delay_mc: three variants share stimulus.
module tb_variable_delay_mc;

  localparam int DIV  = 16;
  localparam int N    = 3;
  localparam int HOLD = (N + 2) * DIV;
  localparam int NV   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] din;
  logic       btn_up, btn_dn;
  logic [2:0] dout_v [NV];
  logic [3:0] len_v  [NV];
  logic       chg_v  [NV];

  int errors = 0;
  int checks = 0;
  int mlen   [NV];
  int pulses [NV];
  int depth_of [NV] = '{16, 16, 12};
  int wrap_of  [NV] = '{1, 0, 1};
  logic [2:0] din_hist [$];

  always #5 clk = ~clk;

  variable_delay_mc #(.CH(3), .DEPTH(16), .DIV(DIV), .N(N), .WRAP(1)) dut_wrap (
    .clk(clk), .rst(rst), .din(din), .btn_up_raw(btn_up), .btn_dn_raw(btn_dn),
    .dout(dout_v[0]), .len(len_v[0]), .len_changed(chg_v[0]));

  variable_delay_mc #(.CH(3), .DEPTH(16), .DIV(DIV), .N(N), .WRAP(0)) dut_sat (
    .clk(clk), .rst(rst), .din(din), .btn_up_raw(btn_up), .btn_dn_raw(btn_dn),
    .dout(dout_v[1]), .len(len_v[1]), .len_changed(chg_v[1]));

  variable_delay_mc #(.CH(3), .DEPTH(12), .DIV(DIV), .N(N), .WRAP(1)) dut_d12 (
    .clk(clk), .rst(rst), .din(din), .btn_up_raw(btn_up), .btn_dn_raw(btn_dn),
    .dout(dout_v[2]), .len(len_v[2]), .len_changed(chg_v[2]));

  // Count every cycle in which len_changed is high, per variant.
  always @(negedge clk) begin
    for (int i = 0; i < NV; i++) if (chg_v[i]) pulses[i]++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference stepping rule, written directly from the wrap/saturate rules.
  function automatic int step_model(input int cur, input int depth, input int wrap,
                                    input bit up, input bit dn);
    if (up && !dn) return (cur == depth - 1) ? (wrap != 0 ? 0 : cur) : cur + 1;
    if (dn && !up) return (cur == 0) ? (wrap != 0 ? depth - 1 : cur) : cur - 1;
    return cur;
  endfunction

  task automatic clear_pulses();
    for (int i = 0; i < NV; i++) pulses[i] = 0;
  endtask

  // Bounce the selected button(s), hold, release, then compare with the model.
  task automatic applyStimulus(input bit up, input bit dn);
    bit r;
    int nl;
    clear_pulses();
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #2;
      r = 1'($urandom_range(0, 1));
      if (up) btn_up = r;
      if (dn) btn_dn = r;
    end
    @(posedge clk); #2;
    btn_up = up;
    btn_dn = dn;
    repeat (HOLD) @(posedge clk);
    #2;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (HOLD) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      nl = step_model(mlen[i], depth_of[i], wrap_of[i], up, dn);
      checkOutput($sformatf("len[v%0d]", i), 32'(len_v[i]), 32'(nl));
      checkOutput($sformatf("pulses[v%0d]", i), 32'(pulses[i]), (nl != mlen[i]) ? 32'd1 : 32'd0);
      mlen[i] = nl;
    end
  endtask

  // Drive walking/random patterns and compare each dout with din from len cycles ago.
  task automatic check_delay(input int cycles, input string tag);
    din_hist.delete();
    for (int k = 0; k < 16; k++) din_hist.push_front(din);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #2;
      case (c % 4)
        0:       din = 3'($urandom);
        1:       din = 3'b001 << (c % 3);
        2:       din = ~(3'b001 << (c % 3));
        default: din = 3'b100 >> (c % 3);
      endcase
      din_hist.push_front(din);
      void'(din_hist.pop_back());
      @(negedge clk);
      for (int i = 0; i < NV; i++)
        checkOutput($sformatf("%s dout[v%0d]", tag, i), 32'(dout_v[i]), 32'(din_hist[mlen[i]]));
    end
  endtask

  task automatic check_all_zero_len(input string tag);
    for (int i = 0; i < NV; i++) begin
      checkOutput($sformatf("%s len[v%0d]", tag, i), 32'(len_v[i]), 32'd0);
      checkOutput($sformatf("%s chg[v%0d]", tag, i), 32'(chg_v[i]), 32'd0);
      checkOutput($sformatf("%s bypass[v%0d]", tag, i), 32'(dout_v[i]), 32'(din));
    end
  endtask

  initial begin
    int guard;
    rst    = 1'b1;
    din    = 3'b000;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    for (int i = 0; i < NV; i++) mlen[i] = 0;
    clear_pulses();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero_len("reset");
    din = 3'b110;
    #1;
    check_all_zero_len("reset-din");
    @(posedge clk); #2;
    rst = 1'b0;

    // Bypass: dout follows din within 1 time unit, no edge needed.
    clear_pulses();
    din = 3'b101;
    #1;
    for (int i = 0; i < NV; i++) checkOutput($sformatf("bypass0[v%0d]", i), 32'(dout_v[i]), 32'(din));
    for (int k = 0; k < 4; k++) begin
      #3;
      din = 3'($urandom);
      #1;
      for (int i = 0; i < NV; i++) checkOutput($sformatf("bypass%0d[v%0d]", k + 1, i), 32'(dout_v[i]), 32'(din));
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NV; i++) checkOutput($sformatf("idle pulses[v%0d]", i), 32'(pulses[i]), 32'd0);

    // First step to len=1, then a single-cycle pulse on din[0].
    din = 3'b000;
    applyStimulus(1'b1, 1'b0);
    @(posedge clk); #2; din = 3'b001;
    @(negedge clk);
    for (int i = 0; i < NV; i++) checkOutput($sformatf("pulse t0[v%0d]", i), 32'(dout_v[i][0]), 32'd0);
    @(posedge clk); #2; din = 3'b000;
    @(negedge clk);
    for (int i = 0; i < NV; i++) checkOutput($sformatf("pulse t1[v%0d]", i), 32'(dout_v[i][0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NV; i++) checkOutput($sformatf("pulse t2[v%0d]", i), 32'(dout_v[i][0]), 32'd0);

    // len=5 with walking patterns on all channels.
    repeat (4) applyStimulus(1'b1, 1'b0);
    check_delay(50, "len5");

    // Climb to the top (DEPTH=12 variant wraps 11->0 on the way), then cross both ends.
    repeat (10) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);

    // Down to len=7 on the wrap variant, then a simultaneous press must do nothing.
    repeat (8) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);

    // Walk down through the saturating floor and the wrapping floor.
    repeat (7) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    check_delay(30, "mixed");

    // Bring the wrap variant to len=9.
    guard = 0;
    while (mlen[0] != 9 && guard < 20) begin
      applyStimulus(1'b1, 1'b0);
      guard++;
    end
    checkOutput("reach len9", 32'(len_v[0]), 32'd9);

    // Reset while a press is only partly debounced.
    @(posedge clk); #2;
    btn_up = 1'b1;
    repeat (DIV + DIV / 2 + 2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero_len("midrst");
    btn_up = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < NV; i++) mlen[i] = 0;
    clear_pulses();
    repeat (2 * HOLD) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      checkOutput($sformatf("post-rst len[v%0d]", i), 32'(len_v[i]), 32'd0);
      checkOutput($sformatf("post-rst pulses[v%0d]", i), 32'(pulses[i]), 32'd0);
    end

    // Button held across the reset release gives exactly one step.
    @(posedge clk); #2;
    btn_up = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    clear_pulses();
    repeat (HOLD) @(posedge clk);
    #2;
    btn_up = 1'b0;
    repeat (HOLD) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      checkOutput($sformatf("held len[v%0d]", i), 32'(len_v[i]), 32'd1);
      checkOutput($sformatf("held pulses[v%0d]", i), 32'(pulses[i]), 32'd1);
      mlen[i] = 1;
    end
    check_delay(10, "len1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
